csr_access_arbiter: RTL and testbench

CSR_ACCESS_ARBITER -- requirements
Module: csr_access_arbiter

---
 rtl/csr_access_arbiter.sv | 172 +++++++++++++++++
 tb/tb_csr_access_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_arbiter.sv
// Two-requester arbiter (core, ext) for a single-ported CSR bank: IDLE grants, ACCESS drives the bank, RESP returns the old value.
// Define CSR_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise core has priority with a starvation guard for ext.

package csr_arb_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [4:0]  csr_r_t;
  typedef logic [31:0] csr_word_t;

  // RISC-V funct3 encodings; CSR_NONE is the idle value driven to the bank.
  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSRRW    = 3'b001,
    CSRRS    = 3'b010,
    CSRRC    = 3'b011,
    CSRRWI   = 3'b101,
    CSRRSI   = 3'b110,
    CSRRCI   = 3'b111
  } csr_op_t;

endpackage

module csr_access_arbiter
  import csr_arb_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic      clk,
  input  logic      reset,

  input  logic      core_req,
  input  csr_addr_t core_addr,
  input  csr_op_t   core_op,
  input  csr_r_t    core_zimm,
  input  csr_word_t core_data,
  output logic      core_gnt,
  output logic      core_rvalid,

  input  logic      ext_req,
  input  csr_addr_t ext_addr,
  input  csr_op_t   ext_op,
  input  csr_r_t    ext_zimm,
  input  csr_word_t ext_data,
  output logic      ext_gnt,
  output logic      ext_rvalid,

  output csr_word_t rdata,

  output logic      csr_enable,
  output csr_addr_t csr_addr,
  output csr_op_t   csr_op,
  output csr_r_t    rs1_zimm,
  output csr_word_t rs1_data,
  input  csr_word_t csr_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e    state_q, state_d;
  csr_addr_t addr_q;
  csr_op_t   op_q;
  csr_r_t    zimm_q;
  csr_word_t data_q;
  logic      winner_ext_q;
  csr_word_t rdata_q;

  logic      any_req;
  logic      ext_wins;
  logic      grant_valid;
  logic      in_access;

  assign any_req = core_req | ext_req;

`ifdef CSR_ARB_ROUND_ROBIN_EN
  // Points at the requester granted last; reset to ext so core wins the first tie.
  logic last_ext_q, last_ext_d;

  assign ext_wins = ext_req & (~core_req | ~last_ext_q);
`else
  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  logic [3:0] starve_q, starve_d;

  assign ext_wins = ext_req & (~core_req | (starve_q == StarveMax));
`endif

  // Grants are suppressed while reset is high so a requester never sees a grant whose access is discarded.
  assign grant_valid = (state_q == S_IDLE) & any_req & ~reset;
  assign core_gnt    = grant_valid & ~ext_wins;
  assign ext_gnt     = grant_valid &  ext_wins;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef CSR_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_ext_d = last_ext_q;
    if (grant_valid) last_ext_d = ext_wins;
  end
`else
  // A waiting ext accrues credit per core grant it loses; leaving or winning clears it.
  always_comb begin
    starve_d = starve_q;
    if (!ext_req || ext_gnt) begin
      starve_d = '0;
    end else if (core_gnt && (starve_q < StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end
`endif

  // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the request/response datapath is reset too, because rdata and every csr_* output must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      op_q         <= CSR_NONE;
      zimm_q       <= '0;
      data_q       <= '0;
      winner_ext_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        addr_q       <= ext_wins ? ext_addr : core_addr;
        op_q         <= ext_wins ? ext_op   : core_op;
        zimm_q       <= ext_wins ? ext_zimm : core_zimm;
        data_q       <= ext_wins ? ext_data : core_data;
        winner_ext_q <= ext_wins;
      end
      if (state_q == S_ACCESS) rdata_q <= csr_rdata;
    end
  end

`ifdef CSR_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) last_ext_q <= 1'b1;
    else       last_ext_q <= last_ext_d;
  end
`else
  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`endif

  assign in_access = (state_q == S_ACCESS);

  assign csr_enable = in_access;
  assign csr_addr   = in_access ? addr_q : '0;
  assign csr_op     = in_access ? op_q   : CSR_NONE;
  assign rs1_zimm   = in_access ? zimm_q : '0;
  assign rs1_data   = in_access ? data_q : '0;

  assign core_rvalid = (state_q == S_RESP) & ~winner_ext_q & ~reset;
  assign ext_rvalid  = (state_q == S_RESP) &  winner_ext_q & ~reset;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter with a combinational CSR bank stub returning fixed old values.
`timescale 1ns/1ps

module tb_csr_access_arbiter;
  import csr_arb_pkg::*;

  logic      clk;
  logic      reset;
  logic      core_req, ext_req;
  csr_addr_t core_addr, ext_addr;
  csr_op_t   core_op, ext_op;
  csr_r_t    core_zimm, ext_zimm;
  csr_word_t core_data, ext_data;
  logic      core_gnt, ext_gnt, core_rvalid, ext_rvalid;
  csr_word_t rdata;
  logic      csr_enable;
  csr_addr_t csr_addr;
  csr_op_t   csr_op;
  csr_r_t    rs1_zimm;
  csr_word_t rs1_data;
  csr_word_t csr_rdata;

  int n_pass  = 0;
  int n_check = 0;

  csr_access_arbiter #(.StarveLimit(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_addr(core_addr), .core_op(core_op),
    .core_zimm(core_zimm), .core_data(core_data),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_op(ext_op),
    .ext_zimm(ext_zimm), .ext_data(ext_data),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .rdata(rdata),
    .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
    .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_rdata(csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank stub: old value depends only on the addressed CSR.
  always_comb begin
    case (csr_addr)
      12'h305: csr_rdata = 32'h0000_0100;
      12'h300: csr_rdata = 32'h0000_1888;
      default: csr_rdata = {20'hC0FFE, csr_addr};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_ext[6];
    int   ng;
    int   gnt_cyc;
    logic gnt_id;
    logic pending;

`ifdef CSR_ARB_ROUND_ROBIN_EN
    exp_ext = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ext = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    reset = 1'b1;
    core_req = 1'b0; ext_req = 1'b0;
    core_addr = '0; ext_addr = '0;
    core_op = CSRRW; ext_op = CSRRW;
    core_zimm = '0; ext_zimm = '0;
    core_data = '0; ext_data = '0;
    step();
    step();

    // Reset state; a request during reset is not granted.
    core_req = 1'b1;
    #1;
    check("gnt_in_reset", 32'(core_gnt), 32'd0);
    core_req = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_core_gnt", 32'(core_gnt), 32'd0);
    check("rst_ext_gnt", 32'(ext_gnt), 32'd0);
    check("rst_rvalid", 32'({core_rvalid, ext_rvalid}), 32'd0);
    check("rst_csr_en", 32'(csr_enable), 32'd0);
    check("rst_csr_bus", {csr_addr, 1'b0, csr_op, rs1_zimm, 11'd0}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    step();
    check("idle_no_gnt", 32'({core_gnt, ext_gnt}), 32'd0);

    // Core-only CSRRW to 0x305.
    core_addr = 12'h305; core_op = CSRRW; core_data = 32'hDEAD_BEEF; core_zimm = 5'd3;
    core_req = 1'b1;
    #1;
    check("c0_core_gnt", 32'(core_gnt), 32'd1);
    check("c0_ext_gnt", 32'(ext_gnt), 32'd0);
    step();
    core_req = 1'b0;
    #1;
    check("c1_csr_en", 32'(csr_enable), 32'd1);
    check("c1_csr_addr", 32'(csr_addr), 32'h305);
    check("c1_csr_op", 32'(csr_op), 32'(CSRRW));
    check("c1_rs1_data", rs1_data, 32'hDEAD_BEEF);
    check("c1_no_rvalid", 32'(core_rvalid), 32'd0);
    step();
    check("c2_core_rvalid", 32'(core_rvalid), 32'd1);
    check("c2_ext_rvalid", 32'(ext_rvalid), 32'd0);
    check("c2_rdata", rdata, 32'h0000_0100);
    check("c2_csr_en", 32'(csr_enable), 32'd0);
    step();
    check("c3_rvalid_low", 32'(core_rvalid), 32'd0);
    check("c3_rdata_hold", rdata, 32'h0000_0100);

    // Ext CSRRSI zimm=5 on 0x300.
    ext_addr = 12'h300; ext_op = CSRRSI; ext_zimm = 5'd5; ext_data = 32'h1234_5678;
    ext_req = 1'b1;
    #1;
    check("e0_ext_gnt", 32'(ext_gnt), 32'd1);
    check("e0_core_gnt", 32'(core_gnt), 32'd0);
    step();
    ext_req = 1'b0;
    #1;
    check("e1_csr_op", 32'(csr_op), 32'(CSRRSI));
    check("e1_rs1_zimm", 32'(rs1_zimm), 32'd5);
    check("e1_csr_addr", 32'(csr_addr), 32'h300);
    step();
    check("e2_ext_rvalid", 32'(ext_rvalid), 32'd1);
    check("e2_core_rvalid", 32'(core_rvalid), 32'd0);
    check("e2_rdata", rdata, 32'h0000_1888);
    step();
    check("e3_rdata_hold", rdata, 32'h0000_1888);

    // Core drops its request before a grant while ext waits.
    core_addr = 12'h340; core_op = CSRRC; core_data = 32'h1;
    core_req = 1'b1;
    #1;
    check("d0_core_gnt", 32'(core_gnt), 32'd1);
    step();
    ext_addr = 12'h341; ext_op = CSRRS; ext_data = 32'hF0;
    ext_req = 1'b1;
    step();
    core_req = 1'b0;
    check("d1_rdata_first", rdata, 32'hC0FF_E340);
    step();
    check("d2_ext_gnt", 32'(ext_gnt), 32'd1);
    check("d2_core_gnt", 32'(core_gnt), 32'd0);
    step();
    ext_req = 1'b0;
    #1;
    check("d3_csr_addr", 32'(csr_addr), 32'h341);
    check("d3_rs1_data", rs1_data, 32'hF0);
    step();
    check("d4_ext_rvalid", 32'(ext_rvalid), 32'd1);
    check("d4_core_rvalid", 32'(core_rvalid), 32'd0);
    check("d4_rdata", rdata, 32'hC0FF_E341);
    step();

    // Reset pulsed during ACCESS aborts the access.
    core_addr = 12'h305; core_op = CSRRW; core_data = 32'hA;
    core_req = 1'b1;
    #1;
    check("r0_core_gnt", 32'(core_gnt), 32'd1);
    step();
    core_req = 1'b0;
    check("r1_csr_en", 32'(csr_enable), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("r2_csr_en", 32'(csr_enable), 32'd0);
    check("r2_csr_addr", 32'(csr_addr), 32'd0);
    check("r2_rvalid", 32'({core_rvalid, ext_rvalid}), 32'd0);
    check("r2_rdata", rdata, 32'd0);
    step();
    check("r3_rvalid", 32'({core_rvalid, ext_rvalid}), 32'd0);
    core_addr = 12'h300;
    core_req = 1'b1;
    #1;
    check("r4_core_gnt", 32'(core_gnt), 32'd1);
    step();
    core_req = 1'b0;
    step();
    check("r6_core_rvalid", 32'(core_rvalid), 32'd1);
    check("r6_rdata", rdata, 32'h0000_1888);
    step();

    // Tie with both requests held high from reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    core_req = 1'b1;
    ext_req = 1'b1;
    core_addr = 12'h305;
    ext_addr = 12'h300;
    #1;
    ng = 0;
    gnt_cyc = 0;
    gnt_id = 1'b0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
      if (core_rvalid || ext_rvalid) begin
        check("tie_rvalid_lat", 32'(cyc - gnt_cyc), 32'd2);
        check("tie_rvalid_id", 32'({pending, ext_rvalid}), 32'({1'b1, gnt_id}));
        pending = 1'b0;
      end
      if (core_gnt || ext_gnt) begin
        check("tie_one_hot", 32'(core_gnt & ext_gnt), 32'd0);
        check($sformatf("tie_order_%0d", ng), 32'(ext_gnt), 32'(exp_ext[ng]));
        gnt_cyc = cyc;
        gnt_id = ext_gnt;
        pending = 1'b1;
        ng++;
      end
      step();
    end
    check("tie_grant_count", 32'(ng), 32'd6);
    core_req = 1'b0;
    ext_req = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
